lavigne_rr_merge: RTL and testbench
===================================

Name: lavigne_rr_merge

Overview:
- Parametrised successor to the fixed two-instance, single-input wrappers.
- Merges NCH independent input channels into one output stream. Each channel has its own DEPTH-entry FIFO.
- A fair round-robin arbiter drains the FIFOs through a registered valid/ready output stage, and every output word is tagged with its source channel.
- Sits between per-channel producer instances and a single downstream consumer.

Parameters:
- NCH, 2, number of input channels (2..16).
- WIDTH, 8, data width per channel.
- DEPTH, 4, per-channel FIFO depth in words; power of 2, at least 2.
- CHW, $clog2(NCH) (minimum 1), width of the channel tag; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  NCH  per-channel word valid.
- in_ready  output  NCH  per-channel FIFO not full.
- in_data  input  NCH*WIDTH  packed data; channel c occupies bits [c*WIDTH +: WIDTH].
- out_valid  output  1  output word valid.
- out_ready  input  1  consumer accepts.
- out_data  output  WIDTH  output word.
- out_chan  output  CHW  source channel of out_data.
- ovf_sticky  output  NCH  per-channel overflow flag; set when in_valid is high while in_ready is low.

Behaviour:
- Reset (rst_n low at a rising edge):
  - All FIFOs are emptied and the round-robin pointer is set to 0.
  - out_valid, out_data, out_chan and ovf_sticky all become 0.
  - in_ready reads all ones from the first cycle after reset.
  - A reset mid-transfer discards all held words, including the word on out_valid. No handshake completes in the reset cycle.
- Input side:
  - A push on channel c occurs when in_valid[c] and in_ready[c] are both high.
  - in_ready[c] = !full[c]. It depends only on stored occupancy; there is no combinational path from out_ready.
  - A full FIFO does not accept a word in the same cycle it is popped. in_ready rises the cycle after the pop.
  - When in_valid[c] is high and in_ready[c] is low, ovf_sticky[c] is set. It is cleared only by reset. The data is not stored.
- FIFO:
  - Circular buffer with log2(DEPTH)+1-bit read/write pointers. Wrap-around is by natural pointer overflow.
  - full when the pointers differ only in the MSB; empty when the pointers are equal.
  - A simultaneous push and pop on a non-full, non-empty FIFO leaves occupancy unchanged.
- Output stage:
  - A single register stage holds out_valid, out_data and out_chan. It loads when out_valid is 0, or when out_valid and out_ready are both 1 (slot freed in the same cycle).
  - On load, the arbiter grants the first non-empty channel searching upward from pointer p, wrapping NCH-1 to 0. It pops that channel's FIFO head into the register, sets out_chan to the granted index and sets out_valid to 1.
  - After a grant to channel g, p becomes (g+1) mod NCH. If nothing is granted, p is unchanged.
  - If no FIFO is non-empty at a load opportunity, out_valid goes to 0 (or stays 0).
  - While out_valid is 1 and out_ready is 0, out_data and out_chan are held stable. No pop occurs.
- Latency:
  - A word pushed into an empty FIFO at edge N, with the output stage free, is visible on the output after edge N+1. That is one cycle of latency.
  - Sustained throughput is one word per cycle when out_ready is held high.
- Fairness: with all channels continuously non-empty, grants cycle 0,1,...,NCH-1,0. No channel waits more than NCH-1 grants.
- Ordering: words from the same channel are output in arrival order.
- Width rules:
  - out_chan is zero-extended to CHW bits.
  - When NCH is not a power of 2, the pointer wrap uses an explicit compare against NCH-1 and never indexes a nonexistent channel.

Test Plan:
- Reset then idle: rst_n low for 2 cycles, then high -> out_valid=0, in_ready=2'b11, ovf_sticky=0, out_chan=0.
- Single word, NCH=2, WIDTH=8: push 8'hA5 on ch1 at edge 3 with out_ready=1 -> out_valid=1, out_data=8'hA5, out_chan=1 after edge 4; out_valid=0 after edge 5.
- Fairness: preload ch0 with 10,11,12 and ch1 with 20,21,22, then hold out_ready=1 -> output sequence (10,0),(20,1),(11,0),(21,1),(12,0),(22,1).
- Backpressure and full: DEPTH=4, out_ready=0, push 5 words on ch0 -> first word moves into the output register, FIFO reaches 4 entries, in_ready[0] drops, 6th push attempt sets ovf_sticky[0]. out_data stays at the first word until out_ready=1, and in_ready[0] rises one cycle after the first pop.
- Wrap-around: push and pop 9 words through ch0 with DEPTH=4 (pointers wrap twice) -> all 9 words emerge in order, with no spurious full or empty.
- Reset mid-operation: rst_n low while out_valid=1 and both FIFOs hold 3 words -> next cycle out_valid=0, all FIFOs empty, pointer 0; the first post-reset grant goes to ch0 when both channels have data.

Source files
------------

// File: rtl/lavigne_rr_merge.sv
`default_nettype none
// ============================================================================
// lavigne_rr_merge : NCH per-channel FIFOs merged by a round-robin arbiter
//                    into one registered valid/ready stream tagged by channel.
// Revision: 1.0
// ============================================================================
module lavigne_rr_merge #(
  parameter int NCH   = 2,
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [CHW-1:0]       out_chan,
  output logic [NCH-1:0]       ovf_sticky
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [NCH][DEPTH];
  logic [AW:0]      wr_q  [NCH];
  logic [AW:0]      rd_q  [NCH];

  logic [NCH-1:0]   full_w;
  logic [NCH-1:0]   empty_w;
  logic [NCH-1:0]   push_w;
  logic [NCH-1:0]   pop_w;

  logic             load_w;
  logic             found_w;
  logic [CHW-1:0]   gnt_w;
  logic [WIDTH-1:0] head_w;

  logic [CHW-1:0]   ptr_q,       ptr_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [CHW-1:0]   out_chan_q,  out_chan_d;
  logic [NCH-1:0]   ovf_q,       ovf_d;

  assign load_w = !out_valid_q || out_ready;

  // Full when pointers differ only in the wrap bit.
  for (genvar c = 0; c < NCH; c++) begin : g_chan
    assign full_w[c]  = (wr_q[c] ^ rd_q[c]) == {1'b1, {AW{1'b0}}};
    assign empty_w[c] = (wr_q[c] == rd_q[c]);
    assign push_w[c]  = in_valid[c] & ~full_w[c];
    assign pop_w[c]   = load_w & found_w & (gnt_w == CHW'(c));
  end

  // Scan downward in rotation order so the closest non-empty channel at or
  // after the pointer is the last (and winning) assignment.
  always_comb begin
    int             idx;
    logic [CHW-1:0] sel;
    idx     = 0;
    sel     = '0;
    found_w = 1'b0;
    gnt_w   = '0;
    head_w  = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = int'(ptr_q) + k;
      if (idx >= NCH) idx = idx - NCH;
      sel = CHW'(idx);
      if (!empty_w[sel]) begin
        found_w = 1'b1;
        gnt_w   = sel;
        head_w  = mem_q[sel][rd_q[sel][AW-1:0]];
      end
    end
  end

  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    ovf_d       = ovf_q | (in_valid & full_w);
    if (load_w) begin
      out_valid_d = found_w;
      if (found_w) begin
        out_data_d = head_w;
        out_chan_d = gnt_w;
        ptr_d      = (gnt_w == CHW'(NCH - 1)) ? '0 : gnt_w + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        wr_q[c] <= '0;
        rd_q[c] <= '0;
      end
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      ovf_q       <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        wr_q[c] <= wr_q[c] + {{AW{1'b0}}, push_w[c]};
        rd_q[c] <= rd_q[c] + {{AW{1'b0}}, pop_w[c]};
      end
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      ovf_q       <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (rst_n && push_w[c]) mem_q[c][wr_q[c][AW-1:0]] <= in_data[c*WIDTH +: WIDTH];
    end
  end

  assign in_ready   = ~full_w;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_chan   = out_chan_q;
  assign ovf_sticky = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_lavigne_rr_merge.sv
`default_nettype none
// ============================================================================
// tb_lavigne_rr_merge : directed bench with a queue-based reference model.
// Revision: 1.0
// ============================================================================
module tb_lavigne_rr_merge;

  localparam int NCH   = 2;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CHW   = 1;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic [NCH*WIDTH-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_data;
  logic [CHW-1:0]       out_chan;
  logic [NCH-1:0]       ovf_sticky;

  lavigne_rr_merge #(.NCH(NCH), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_chan(out_chan), .ovf_sticky(ovf_sticky)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one queue per channel plus the visible output word.
  logic [WIDTH-1:0] mq [NCH][$];
  logic             mv;
  logic [WIDTH-1:0] md;
  int               mc;
  int               mp;
  logic [NCH-1:0]   movf;
  logic [NCH-1:0]   mpush;
  logic [NCH-1:0]   exp_rdy;
  bit               mfound;
  int               hs_c[$];
  int               hs_d[$];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) mq[c].delete();
      mv = 1'b0; md = '0; mc = 0; mp = 0; movf = '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        mpush[c] = in_valid[c] && (mq[c].size() < DEPTH);
        if (in_valid[c] && mq[c].size() >= DEPTH) movf[c] = 1'b1;
      end
      if (!mv || out_ready) begin
        mfound = 1'b0;
        for (int k = 0; k < NCH; k++) begin
          int c;
          c = (mp + k) % NCH;
          if (!mfound && mq[c].size() > 0) begin
            mfound = 1'b1;
            md = mq[c].pop_front();
            mc = c;
            mp = (c + 1) % NCH;
          end
        end
        mv = mfound;
      end
      for (int c = 0; c < NCH; c++)
        if (mpush[c]) mq[c].push_back(in_data[c*WIDTH +: WIDTH]);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int c = 0; c < NCH; c++) exp_rdy[c] = (mq[c].size() < DEPTH);
      chk("model_out_valid", 32'(out_valid), 32'(mv));
      chk("model_in_ready", 32'(in_ready), 32'(exp_rdy));
      chk("model_ovf", 32'(ovf_sticky), 32'(movf));
      if (mv) begin
        chk("model_out_data", 32'(out_data), 32'(md));
        chk("model_out_chan", 32'(out_chan), 32'(mc));
      end
      if (rst_n && out_valid && out_ready) begin
        hs_c.push_back(int'(out_chan));
        hs_d.push_back(int'(out_data));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic [NCH-1:0] v, input logic [7:0] d0, input logic [7:0] d1);
    in_valid = v;
    in_data  = {d1, d0};
  endtask

  int fc [6] = '{0, 1, 0, 1, 0, 1};
  int fd [6] = '{10, 20, 11, 21, 12, 22};

  initial begin
    rst_n = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b1;
    tick(); chk_en = 1'b1;
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'h3);
    chk("rst_ovf", 32'(ovf_sticky), 32'd0);
    chk("rst_out_chan", 32'(out_chan), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    rst_n = 1'b1;

    // Single word on ch1
    drive(2'b10, 8'h00, 8'hA5);
    tick(); drive(2'b00, 8'h00, 8'h00);
    tick();
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_data", 32'(out_data), 32'hA5);
    chk("single_chan", 32'(out_chan), 32'd1);
    tick();
    chk("single_drained", 32'(out_valid), 32'd0);

    // Fairness
    out_ready = 1'b0;
    drive(2'b11, 8'd10, 8'd20); tick();
    drive(2'b11, 8'd11, 8'd21); tick();
    drive(2'b11, 8'd12, 8'd22); tick();
    drive(2'b00, 8'd0, 8'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      chk("fair_valid", 32'(out_valid), 32'd1);
      chk("fair_chan", 32'(out_chan), 32'(fc[i]));
      chk("fair_data", 32'(out_data), 32'(fd[i]));
    end
    tick();
    chk("fair_drained", 32'(out_valid), 32'd0);

    // Backpressure and full
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(2'b01, 8'(8'h30 + i), 8'h00);
      tick();
    end
    chk("bp_full_ready", 32'(in_ready[0]), 32'd0);
    chk("bp_hold_data", 32'(out_data), 32'h30);
    chk("bp_no_ovf_yet", 32'(ovf_sticky[0]), 32'd0);
    drive(2'b01, 8'h35, 8'h00);
    tick();
    chk("bp_ovf_set", 32'(ovf_sticky[0]), 32'd1);
    chk("bp_still_full", 32'(in_ready[0]), 32'd0);
    chk("bp_hold_data2", 32'(out_data), 32'h30);
    out_ready = 1'b1;
    tick();
    drive(2'b00, 8'h00, 8'h00);
    chk("bp_after_pop_data", 32'(out_data), 32'h31);
    chk("bp_ready_rises", 32'(in_ready[0]), 32'd1);
    repeat (5) tick();
    chk("bp_drained", 32'(out_valid), 32'd0);
    chk("bp_ovf_sticks", 32'(ovf_sticky[0]), 32'd1);

    // Wrap-around with sustained traffic
    hs_c.delete(); hs_d.delete();
    for (int i = 0; i < 9; i++) begin
      drive(2'b01, 8'(8'h40 + i), 8'h00);
      tick();
    end
    drive(2'b00, 8'h00, 8'h00);
    repeat (3) tick();
    chk("wrap_count", 32'(hs_d.size()), 32'd9);
    for (int i = 0; i < 9; i++) begin
      if (i < hs_d.size()) begin
        chk("wrap_data", 32'(hs_d[i]), 32'(8'h40 + i));
        chk("wrap_chan", 32'(hs_c[i]), 32'd0);
      end
    end

    // Reset mid-operation with pointer left at 1
    out_ready = 1'b0;
    drive(2'b01, 8'h60, 8'h00); tick();
    drive(2'b11, 8'h61, 8'h68); tick();
    drive(2'b11, 8'h62, 8'h69); tick();
    drive(2'b11, 8'h63, 8'h6A); tick();
    drive(2'b00, 8'h00, 8'h00);
    chk("mid_valid", 32'(out_valid), 32'd1);
    chk("mid_data", 32'(out_data), 32'h60);
    chk("mid_ch1_not_full", 32'(in_ready[1]), 32'd1);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'h3);
    chk("mid_rst_ovf", 32'(ovf_sticky), 32'd0);
    chk("mid_rst_chan", 32'(out_chan), 32'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(2'b11, 8'h70, 8'h80); tick();
    drive(2'b00, 8'h00, 8'h00); tick();
    chk("post_rst_chan0", 32'(out_chan), 32'd0);
    chk("post_rst_data0", 32'(out_data), 32'h70);
    tick();
    chk("post_rst_chan1", 32'(out_chan), 32'd1);
    chk("post_rst_data1", 32'(out_data), 32'h80);
    tick();
    chk("post_rst_drained", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
